// File: rtl/cpp_fp_pkg.sv
// rtl/cpp_fp_pkg.sv - shared constants and enums for the double-to-int32 converter
package cpp_fp_pkg;

    localparam int DBL_EXP_W  = 11;
    localparam int DBL_FRAC_W = 52;
    localparam int DBL_BIAS   = 1023;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    localparam int RND_TRUNC     = 0;
    localparam int RND_HALF_AWAY = 1;

    typedef enum logic [1:0] {IDLE, ALIGN, ROUND} cvt_state_t;

    typedef enum logic [1:0] {NORMAL, ZERO, INF, NAN} fp_class_t;

endpackage

// File: rtl/cpp_dbl_align_shift.sv
// rtl/cpp_dbl_align_shift.sv - 53-bit mantissa right shifter producing magnitude, guard and overflow flag
module cpp_dbl_align_shift
    import cpp_fp_pkg::*;
(
    input  logic [DBL_FRAC_W:0] mant,
    input  logic [5:0]          shamt,
    output logic [31:0]         mag,
    output logic                guard,
    output logic                too_large
);

    // One extra LSB below the mantissa catches the last bit shifted out.
    logic [DBL_FRAC_W+1:0] ext;

    assign ext       = {mant, 1'b0} >> shamt;
    assign mag       = ext[32:1];
    assign guard     = ext[0];
    assign too_large = |ext[DBL_FRAC_W+1:33];

endmodule

// File: rtl/cpp_internal_double_to_int_convert.sv
// rtl/cpp_internal_double_to_int_convert.sv - toggle-event IEEE double to int32 converter with saturation
module cpp_internal_double_to_int_convert
    import cpp_fp_pkg::*;
#(
    parameter int ROUND_MODE = 0,
    parameter int SATURATE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] in,
    input  logic        update_in,
    output logic [31:0] out,
    output logic        update_out,
    output logic        ovf,
    output logic        invalid,
    output logic        busy
);

    cvt_state_t  state;
    logic        upd_seen;
    logic [63:0] in_q;
    logic [31:0] mag_q;
    logic        guard_q;
    logic        big_q;
    logic        sign_q;
    fp_class_t   cls_q;

    logic [DBL_EXP_W-1:0]  exp_f;
    logic [DBL_FRAC_W-1:0] frac_f;
    logic [DBL_FRAC_W:0]   mant;
    logic signed [12:0]    exp_unb;
    logic [5:0]            shamt;
    logic [31:0]           sh_mag;
    logic                  sh_guard;
    logic                  sh_big;
    logic                  exact_min;

    assign exp_f     = in_q[62:52];
    assign frac_f    = in_q[51:0];
    assign mant      = {exp_f != '0, frac_f};
    assign exp_unb   = $signed({2'b00, exp_f}) - 13'sd1023;
    assign exact_min = in_q[63] && (exp_unb == 13'sd31) && (frac_f == '0);

    // Exponents beyond 52 keep shamt at 0 so the shifter flags them as too large.
    always_comb begin
        shamt = '0;
        if (exp_unb >= 13'sd0 && exp_unb <= 13'sd52)
            shamt = 6'(13'sd52 - exp_unb);
    end

    cpp_dbl_align_shift u_shift (
        .mant      (mant),
        .shamt     (shamt),
        .mag       (sh_mag),
        .guard     (sh_guard),
        .too_large (sh_big)
    );

    logic [32:0] sum;
    logic        range_ovf;
    logic [31:0] sat_val;

    assign sum       = {1'b0, mag_q} + {32'b0, (ROUND_MODE == RND_HALF_AWAY) && guard_q};
    assign range_ovf = big_q || (sign_q ? (sum > 33'h0_8000_0000) : (sum > 33'h0_7FFF_FFFF));
    assign sat_val   = (SATURATE != 0) ? (sign_q ? INT32_MIN : INT32_MAX) : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            upd_seen   <= update_in;
            in_q       <= '0;
            mag_q      <= '0;
            guard_q    <= 1'b0;
            big_q      <= 1'b0;
            sign_q     <= 1'b0;
            cls_q      <= NORMAL;
            out        <= '0;
            update_out <= 1'b0;
            ovf        <= 1'b0;
            invalid    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (update_in != upd_seen) begin
                        in_q     <= in;
                        upd_seen <= update_in;
                        busy     <= 1'b1;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    sign_q <= in_q[63];
                    if (exp_f == '1) begin
                        cls_q   <= (frac_f != '0) ? NAN : INF;
                        mag_q   <= '0;
                        guard_q <= 1'b0;
                        big_q   <= 1'b0;
                    end else if (exp_unb < 13'sd0) begin
                        // Values in [0.5, 1) carry their half bit so half-away rounding yields 1.
                        cls_q   <= ZERO;
                        mag_q   <= '0;
                        guard_q <= (exp_unb == -13'sd1);
                        big_q   <= 1'b0;
                    end else begin
                        cls_q   <= NORMAL;
                        mag_q   <= sh_mag;
                        guard_q <= sh_guard;
                        big_q   <= sh_big || ((exp_unb >= 13'sd31) && !exact_min);
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    case (cls_q)
                        NAN: begin
                            out     <= '0;
                            ovf     <= 1'b0;
                            invalid <= 1'b1;
                        end
                        INF: begin
                            out     <= sat_val;
                            ovf     <= 1'b1;
                            invalid <= 1'b0;
                        end
                        default: begin
                            invalid <= 1'b0;
                            if (range_ovf) begin
                                out <= sat_val;
                                ovf <= 1'b1;
                            end else begin
                                out <= sign_q ? (32'h0 - sum[31:0]) : sum[31:0];
                                ovf <= 1'b0;
                            end
                        end
                    endcase
                    update_out <= ~update_out;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
